// File: rtl/lsu_bus_adapter_pkg.sv
// rtl/lsu_bus_adapter_pkg.sv - shared constants, FSM states and helpers for the LSU bus adapter
package lsu_bus_adapter_pkg;

  localparam int XLEN   = 64;
  localparam int XBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(XBYTES);

  localparam logic [XBYTES-1:0] BYTES_B = 8'h01;
  localparam logic [XBYTES-1:0] BYTES_H = 8'h03;
  localparam logic [XBYTES-1:0] BYTES_W = 8'h0F;
  localparam logic [XBYTES-1:0] BYTES_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Access size minus one, read straight off the contiguous byte mask (0x03 -> 1, 0xFF -> 7).
  function automatic logic [OFF_W-1:0] size_mask(input logic [XBYTES-1:0] bytes);
    logic [OFF_W-1:0] m;
    m = '0;
    for (int i = 0; i < OFF_W; i++) begin
      m[i] = bytes[(1 << (i + 1)) - 1];
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_bus_adapter_align.sv
// rtl/lsu_bus_adapter_align.sv - combinational lane shift, strobe generation and read extraction
module lsu_align
  import lsu_bus_adapter_pkg::*;
(
  input  logic [XBYTES-1:0] req_bytes,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XBYTES-1:0] rsp_bytes,
  input  logic [OFF_W-1:0]  rsp_off,
  input  logic [XLEN-1:0]   rsp_rdata,
  output logic [OFF_W-1:0]  eff_off,
  output logic [XBYTES-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] lane_mask;

  always_comb begin
    // Offset bits below the access size are dropped so the access never straddles its natural slot.
    eff_off = req_off & ~size_mask(req_bytes);
    wstrb   = req_bytes << eff_off;
    wdata   = req_wdata << {eff_off, 3'b000};
    for (int i = 0; i < XBYTES; i++) begin
      lane_mask[8*i +: 8] = {8{rsp_bytes[i]}};
    end
    rdata = (rsp_rdata >> {rsp_off, 3'b000}) & lane_mask;
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// rtl/lsu_bus_adapter.sv - execute-stage load/store to single-beat memory bus adapter
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acs_en,
  input  logic              acs_wr,
  input  logic [XBYTES-1:0] acs_bytes,
  input  logic [XLEN-1:0]   acs_addr,
  input  logic [XLEN-1:0]   acs_wdata,
  output logic [XLEN-1:0]   acs_rdata,
  output logic              lsu_stall,
  output logic              misalign_exc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XBYTES-1:0] mem_req_wstrb,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              acc_fault
);

  lsu_state_e        state_q, state_d;
  logic [XBYTES-1:0] bytes_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic              mis_q;
  logic              misalign_hit;
  logic [OFF_W-1:0]  eff_off;
  logic [XBYTES-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;

  lsu_align u_align (
    .req_bytes (acs_bytes),
    .req_off   (acs_addr[OFF_W-1:0]),
    .req_wdata (acs_wdata),
    .rsp_bytes (bytes_q),
    .rsp_off   (off_q),
    .rsp_rdata (mem_rsp_rdata),
    .eff_off   (eff_off),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .rdata     (al_rdata)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_hit = |(acs_addr[OFF_W-1:0] & size_mask(acs_bytes));
`else
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acs_en) state_d = misalign_hit ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wstrb <= '0;
      mem_req_wdata <= '0;
      bytes_q       <= '0;
      off_q         <= '0;
      rdata_q       <= '0;
      fault_q       <= 1'b0;
      mis_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acs_en) begin
            mem_req_wr    <= acs_wr;
            mem_req_addr  <= {acs_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wstrb <= al_wstrb;
            mem_req_wdata <= al_wdata;
            bytes_q       <= acs_bytes;
            off_q         <= eff_off;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            mis_q         <= misalign_hit;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_err ? '0 : al_rdata;
            fault_q <= mem_rsp_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is gated by reset so every output reads zero while reset is held.
  assign lsu_stall     = rst_n & acs_en & (state_q != ST_DONE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign acs_rdata     = rdata_q;
  assign acc_fault     = (state_q == ST_DONE) & fault_q;
  assign misalign_exc  = (state_q == ST_DONE) & mis_q;

endmodule

// File: doc/lsu_bus_adapter.md
LSU_BUS_ADAPTER -- requirements
Module: lsu_bus_adapter

Interface
REQ-001 SHALL expose `clk`, input, 1, the single clock; every register is rising-edge triggered.
REQ-002 SHALL expose `rst_n`, input, 1, the reset; it is asynchronous and active-low.
REQ-003 SHALL expose execute-side inputs from the execute stage, all input, sampled in IDLE only:
- `acs_en`, 1, access request.
- `acs_wr`, 1, 1 = store.
- `acs_bytes`, XLEN/8, contiguous low-aligned byte mask; legal values 0x01, 0x03, 0x0F, 0xFF.
- `acs_addr`, XLEN, byte address.
- `acs_wdata`, XLEN, store data, right-aligned.
REQ-004 SHALL expose execute-side outputs:
- `acs_rdata`, output, XLEN, load data, right-aligned, zero above the `acs_bytes` width.
- `lsu_stall`, output, 1, holds PC and instruction.
- `misalign_exc`, output, 1, misaligned-access pulse.
REQ-005 SHALL expose the memory request channel:
- `mem_req_valid`, output, 1.
- `mem_req_ready`, input, 1.
- `mem_req_wr`, output, 1.
- `mem_req_addr`, output, XLEN, XLEN/8-byte aligned.
- `mem_req_wstrb`, output, XLEN/8.
- `mem_req_wdata`, output, XLEN, lane-shifted.
REQ-006 SHALL expose the memory response channel:
- `mem_rsp_valid`, input, 1.
- `mem_rsp_rdata`, input, XLEN.
- `mem_rsp_err`, input, 1.
- `acc_fault`, output, 1, bus-error pulse.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-008 SHALL, in IDLE with `acs_en`=1, register address, write flag, strobe and shifted data, then go to REQ.
REQ-009 SHALL drive `mem_req_valid`=1 in REQ, keeping all `mem_req_*` stable until `mem_req_ready`=1; on handshake it SHALL go to WAIT.
REQ-010 SHALL, in WAIT, go to DONE on `mem_rsp_valid`, capturing the data. Writes also receive a response (ack).
REQ-011 SHALL set `mem_req_addr` = `acs_addr` with the low log2(XLEN/8) bits cleared.
REQ-012 SHALL set `mem_req_wstrb` = `acs_bytes` << offset and `mem_req_wdata` = `acs_wdata` << (8*offset), where offset = the low `acs_addr` bits.
REQ-013 SHALL produce `acs_rdata` = (`mem_rsp_rdata` >> 8*offset) masked by `acs_bytes`; it is registered at capture and held through DONE. Sign extension is not performed here.
REQ-014 SHALL drive `lsu_stall` = `acs_en` & (state != DONE). It is combinational, so the same-cycle request stalls immediately.
REQ-015 SHALL hold DONE for exactly one cycle, then return to IDLE; the instruction commits in DONE and a new request is accepted no earlier than the next cycle.
REQ-016 SHALL give a minimum latency, with ready and response both immediate, of IDLE→REQ→WAIT→DONE: 3 stall cycles, with commit in the 4th cycle.
REQ-017 SHALL ignore `mem_rsp_valid` outside WAIT and `mem_req_ready` outside REQ.
REQ-018 SHALL, on `mem_rsp_err`=1 with `mem_rsp_valid`, pulse `acc_fault` in DONE and leave `acs_rdata`=0.
REQ-019 SHALL accept `acs_en`=0 in IDLE as a no-op: no bus activity and `lsu_stall`=0.

Reset
REQ-020 SHALL, while `rst_n`=0, force state IDLE and drive all outputs and registers to 0, including mid-transaction.
REQ-021 SHALL abandon any transaction in flight when reset asserts; no response is awaited after release.

Configuration
REQ-022 SHALL, with `LSU_MISALIGN_CHECK_EN` defined, treat as misaligned any access where offset is not a multiple of its size. Such an access SHALL:
- go IDLE→DONE directly, with no bus request;
- pulse `misalign_exc` in DONE;
- return `acs_rdata`=0.
REQ-023 SHALL, without `LSU_MISALIGN_CHECK_EN`, tie `misalign_exc` to 0 and clear offset bits below the access size before issuing.

Structure
REQ-024 SHALL place in the shared package: the XLEN and XLEN/8 constants, the FSM state enum, and the byte-mask legal-value constants.
REQ-025 SHALL put the lane shift, strobe generation and read extraction in sub-module `lsu_align`, which is purely combinational.

Verification
REQ-026 SHALL cover an aligned load: lw at 0x1004, ready=1, response 0xAABBCCDD_11223344 after 1 cycle. Required: `mem_req_addr`=0x1000; `acs_rdata`=0xAABBCCDD; stall for 3 cycles.
REQ-027 SHALL cover a byte store: sb at 0x2003, `acs_wdata`=0x5A. Required: wstrb=0x08 and wdata[31:24]=0x5A.
REQ-028 SHALL cover backpressure: `mem_req_ready`=0 for 5 cycles. Required: request fields stable and stall held; commit occurs 3 cycles after ready.
REQ-029 SHALL cover misalignment with the macro defined: lh at 0x3001. Required: no `mem_req_valid`, `misalign_exc` pulses in the 2nd cycle, `acs_rdata`=0.
REQ-030 SHALL cover a bus error: response with `mem_rsp_err`=1. Required: `acc_fault` pulses for 1 cycle and `acs_rdata`=0.
REQ-031 SHALL cover reset in WAIT: `rst_n` low mid-transaction, then a late `mem_rsp_valid`. Required: state IDLE, outputs 0, and the response ignored.
